// File: rtl/uart_rx_port_if.sv
// Bus-side signal bundle for uart_rx_port: read strobe, address, read data and status flags.
// The master modport is the bus initiator; the slave modport is the receive port itself.
interface uart_rx_port_if;
    logic        re;
    logic [31:0] address;
    logic [31:0] dataOut;
    logic        avail;
    logic        err;

    modport master (output re, address, input dataOut, avail, err);
    modport slave  (input re, address, output dataOut, avail, err);
endinterface

// File: rtl/uart_rx_port.sv
// uart_rx_port: 8N1 serial receiver that packs four bytes MSB-first into 32-bit words,
// queues them in a word FIFO and exposes data/status registers on a simple read bus.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for a low level on the synchronized rx
// START  | half a bit time into the start bit, re-check for a real start
// DATA   | sampling 8 data bits LSB first, one per bit time
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, deliver or discard the byte
module uart_rx_port #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_AW      = 4,
    parameter logic [31:0] DATA_ADDR    = 32'h0000_7004,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_7008
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    uart_rx_port_if.slave   bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic            rx_meta, rx_sync;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            byte_ok;
    logic [7:0]      byte_data;
    logic            frame_evt;
    logic [1:0]      byte_idx;
    logic [31:0]     word;
    logic            push_req;
    logic [31:0]     push_word;
    logic [FIFO_AW:0] wptr, rptr;
    logic [31:0]     mem [2**FIFO_AW];
    logic            empty, full, do_pop, do_push, ovr_evt, stat_clr;
    logic            frame_err, overrun, parity_err;
`ifdef UART_RX_PARITY_EN
    logic            parity_bad, parity_evt;
`endif

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver FSM with down-counting bit timer; byte_ok/frame_evt are single-cycle registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_ok   <= 1'b0;
            byte_data <= '0;
            frame_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
            parity_evt <= 1'b0;
`endif
        end else begin
            byte_ok   <= 1'b0;
            frame_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_evt <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                    if (!rx_sync) begin
                        timer <= HALF_LAST;
                        state <= START;
`ifdef UART_RX_PARITY_EN
                        parity_bad <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (timer == '0) begin
                        timer <= BIT_LAST;
                        state <= rx_sync ? IDLE : DATA;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer   <= BIT_LAST;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer == '0) begin
                        timer      <= BIT_LAST;
                        parity_bad <= (rx_sync != ^shift);
                        parity_evt <= (rx_sync != ^shift);
                        state      <= STOP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                            byte_ok <= !parity_bad;
`else
                            byte_ok <= 1'b1;
`endif
                            byte_data <= shift;
                        end else begin
                            frame_evt <= 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte packer: first byte of a word lands in [31:24]; a push request follows the 4th byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx  <= '0;
            word      <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
        end else begin
            push_req <= 1'b0;
            if (byte_ok) begin
                byte_idx <= byte_idx + 1'b1;
                case (byte_idx)
                    2'd0: word[31:24] <= byte_data;
                    2'd1: word[23:16] <= byte_data;
                    2'd2: word[15:8]  <= byte_data;
                    default: begin
                        word[7:0] <= byte_data;
                        push_req  <= 1'b1;
                        push_word <= {word[31:8], byte_data};
                    end
                endcase
            end
        end
    end

    assign empty    = (wptr == rptr);
    assign full     = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                      (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign do_pop   = bus.re && (bus.address == DATA_ADDR) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push_req && (!full || do_pop);
    assign ovr_evt  = push_req && full && !do_pop;
    assign stat_clr = bus.re && (bus.address == STAT_ADDR);

    // FIFO storage; no reset needed since empty masks the head word.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[FIFO_AW-1:0]] <= push_word;
    end

    // FIFO pointers, binary with one extra wrap bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Sticky error bits; a new event in the clearing cycle takes priority over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_evt | (frame_err & ~stat_clr);
            overrun   <= ovr_evt   | (overrun   & ~stat_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error, same set-over-clear rule as the other error bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= parity_evt | (parity_err & ~stat_clr);
    end
`else
    assign parity_err = 1'b0;
`endif

    assign bus.avail = !empty;
    assign bus.err   = frame_err | overrun | parity_err;

    // Zero-latency read mux.
    always_comb begin
        bus.dataOut = '0;
        if (bus.address == DATA_ADDR) begin
            if (!empty) bus.dataOut = mem[rptr[FIFO_AW-1:0]];
        end else if (bus.address == STAT_ADDR) begin
            bus.dataOut = {27'b0, parity_err, frame_err, overrun, full, !empty};
        end
    end
endmodule

// File: doc/uart_rx_port.md
UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit (100 MHz / 115200).
REQ-002 The block SHALL have parameter FIFO_AW, default 4, giving a word FIFO of 2**FIFO_AW entries.
REQ-003 The block SHALL have parameters DATA_ADDR, default 32'h0000_7004, and STAT_ADDR, default 32'h0000_7008, as the memory-mapped register addresses.
REQ-004 The block SHALL have port clk, input, 1, the system clock; all state is in this domain.
REQ-005 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-006 The block SHALL have port rx, input, 1, the serial line, idle high.
REQ-007 The block SHALL have port re, input, 1, a bus read strobe.
REQ-008 The block SHALL have port address, input, 32, the bus address.
REQ-009 The block SHALL have port dataOut, output, 32, the read data.
REQ-010 The block SHALL have port avail, output, 1, which is high when the FIFO is not empty.
REQ-011 The block SHALL have port err, output, 1, the OR of all sticky error bits.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when the REQ-029 macro is defined.
REQ-014 IDLE SHALL go to START when synchronized rx is 0 and clear the bit-timer on entry.
REQ-015 START SHALL wait CLKS_PER_BIT/2 cycles, then go to DATA if rx = 0, otherwise return to IDLE (glitch rejection, nothing recorded).
REQ-016 DATA SHALL sample rx every CLKS_PER_BIT cycles, 8 samples LSB first, then enter STOP, or PARITY when enabled.
REQ-017 STOP SHALL sample after CLKS_PER_BIT cycles and then go to IDLE; rx = 1 delivers the byte to the packer; rx = 0 discards the byte and sets sticky frame_err.
REQ-018 The packer SHALL assemble bytes MSB-first (byte 0 -> [31:24], byte 3 -> [7:0]) to match TX ordering, with a 2-bit index that wraps 3 -> 0 when the word completes.
REQ-019 A completed word SHALL be pushed into the FIFO in the cycle after the 4th byte is accepted.
REQ-020 A push while the FIFO is full and no pop occurs SHALL drop the word and set sticky overrun; the FIFO contents are unchanged.
REQ-021 A pop SHALL occur on re=1, address==DATA_ADDR and avail=1, and then advance the read pointer.
REQ-022 A pop with avail=0 SHALL have no effect.
REQ-023 A simultaneous push and pop while full SHALL both succeed: the count is unchanged and no overrun is set.
REQ-024 dataOut SHALL be combinational, with no read latency:
- address==DATA_ADDR: FIFO head word, or 0 when empty.
- address==STAT_ADDR: {27'b0, parity_err, frame_err, overrun, full, avail}.
- otherwise: 0.
REQ-025 re=1 with address==STAT_ADDR SHALL return the current sticky bits and clear them on the next clk edge; an error setting in that same cycle SHALL win over the clear.
REQ-026 FIFO pointers SHALL be FIFO_AW+1 bits wide binary; full/empty come from pointer compare, and the pointers wrap naturally.

Reset
REQ-027 Reset SHALL force: FSM to IDLE, bit-timer, bit count and byte index to 0, partial word discarded, FIFO pointers to 0, sticky bits to 0, avail=0, err=0, dataOut=0 for DATA_ADDR.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, reception restarts only on a new falling edge.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined:
- PARITY state after DATA samples one even-parity bit.
- A mismatch discards the byte, sets sticky parity_err, and the FSM still proceeds through STOP.
- Without the macro, there is no PARITY state, parity_err is constant 0 and frames are 10 bits.

Verification (bench uses CLKS_PER_BIT=16)
REQ-030 Bench SHALL send bytes 0xDE,0xAD,0xBE,0xEF -> avail=1 after the 4th stop bit; read of 0x7004 = 32'hDEADBEEF; avail=0 after the pop.
REQ-031 Bench SHALL apply a 4-cycle low glitch on idle rx -> no byte accepted, byte index stays 0, err=0.
REQ-032 Bench SHALL send a byte with stop bit = 0 -> byte dropped; status read = 32'h8 and err=1; a second status read = 32'h0.
REQ-033 Bench SHALL send 17 words with no pops (FIFO_AW=4) -> status = 32'h7 (overrun, full, avail); 16 pops return words 1..16 in order.
REQ-034 Bench SHALL assert reset after 2 bytes of a word, then send 4 new bytes -> one word containing only the new bytes.
REQ-035 With UART_RX_PARITY_EN, bench SHALL send 0x01 with parity bit 0 -> byte dropped and status bit4 set; 0x03 with parity bit 0 -> accepted.
